// File: rtl/acc_psum_buffer_bank.sv
// acc_psum_buffer_bank
// Partial-sum accumulation buffer that sits behind the PE array. Each row holds
// NB_LANE signed lanes. An accumulate reads the row, adds the PE outputs (or
// overwrites on the first pass), saturates the result and writes it back two
// cycles later. Results are forwarded between back-to-back accumulates to the
// same row. A drain port reads rows out for the next layer, with optional ReLU
// and a rounded arithmetic right shift.
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   acc_valid       accumulate request; always accepted
//   acc_first       write the PE data without adding the stored value
//   acc_addr        row to accumulate
//   acc_data        PE outputs, lane i at [i*PE_OUT_WIDTH +: PE_OUT_WIDTH]
//   drain_req       drain read request; held by the requester until accepted
//   drain_addr      row to drain
//   drain_relu_en   clamp negative lanes to zero on drain
//   drain_shift     rounded arithmetic right shift amount on drain
//   drain_ready     drain request accepted this cycle
//   drain_valid     drain_data valid (one cycle after acceptance)
//   drain_data      drained row, same lane packing as storage
//   busy            accumulate pipeline holds an in-flight operation
module acc_psum_buffer_bank #(
   parameter int NB_LANE      = 8,
   parameter int PE_OUT_WIDTH = 24,
   parameter int BUF_WIDTH    = 16,
   parameter int BUF_DEPTH    = 8192,
   parameter int ADDR_WIDTH   = $clog2(BUF_DEPTH),
   parameter int SHIFT_WIDTH  = 4
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            acc_valid,
   input  logic                            acc_first,
   input  logic [ADDR_WIDTH-1:0]           acc_addr,
   input  logic [NB_LANE*PE_OUT_WIDTH-1:0] acc_data,
   input  logic                            drain_req,
   input  logic [ADDR_WIDTH-1:0]           drain_addr,
   input  logic                            drain_relu_en,
   input  logic [SHIFT_WIDTH-1:0]          drain_shift,
   output logic                            drain_ready,
   output logic                            drain_valid,
   output logic [NB_LANE*BUF_WIDTH-1:0]    drain_data,
   output logic                            busy
);

   localparam int SUM_W = PE_OUT_WIDTH + 1;
   localparam int ROW_W = NB_LANE * BUF_WIDTH;
   localparam int PE_W  = NB_LANE * PE_OUT_WIDTH;

   localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((2 ** (BUF_WIDTH - 1)) - 1);
   localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;

   logic [ROW_W-1:0]      mem [BUF_DEPTH];
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [ROW_W-1:0]      rd_word;
   logic [ROW_W-1:0]      rd_q;

   logic                  s_valid;
   logic                  s_first;
   logic [ADDR_WIDTH-1:0] s_addr;
   logic [PE_W-1:0]       s_data;
   logic                  fwd;
   logic [ROW_W-1:0]      fwd_data;
   logic [ROW_W-1:0]      wdata;

   logic                  drain_acc;
   logic [ROW_W-1:0]      drain_row;

   function automatic logic [BUF_WIDTH-1:0] acc_lane(
      input logic signed [PE_OUT_WIDTH-1:0] pe,
      input logic signed [BUF_WIDTH-1:0]    op,
      input logic                           first
   );
      logic signed [SUM_W-1:0] a;
      logic signed [SUM_W-1:0] b;
      logic signed [SUM_W-1:0] sum;
      a   = SUM_W'(pe);
      b   = first ? '0 : SUM_W'(op);
      sum = a + b;
      if (sum > SAT_MAX) begin
         return BUF_WIDTH'(SAT_MAX);
      end else if (sum < SAT_MIN) begin
         return BUF_WIDTH'(SAT_MIN);
      end
      return BUF_WIDTH'(sum);
   endfunction

   // Extra headroom bit keeps v + 2^(s-1) from wrapping before the shift.
   function automatic logic [BUF_WIDTH-1:0] drain_lane(
      input logic signed [BUF_WIDTH-1:0] v,
      input logic                        relu,
      input logic [SHIFT_WIDTH-1:0]      sh
   );
      logic signed [BUF_WIDTH:0] ext;
      logic signed [BUF_WIDTH:0] rnd;
      logic signed [BUF_WIDTH:0] tot;
      ext = (relu && (v < 0)) ? '0 : (BUF_WIDTH + 1)'(v);
      if (sh == '0) begin
         return ext[BUF_WIDTH-1:0];
      end
      rnd = '0;
      rnd[sh - 1'b1] = 1'b1;
      tot = ext + rnd;
      tot = tot >>> sh;
      return tot[BUF_WIDTH-1:0];
   endfunction

   // Accumulation always wins the single read port; drain only reads when
   // the pipeline is idle, so the two never contend for the address.
   assign busy        = s_valid;
   assign drain_ready = !acc_valid && !busy;
   assign drain_acc   = drain_req && drain_ready;
   assign rd_addr     = acc_valid ? acc_addr : drain_addr;
   assign rd_word     = mem[rd_addr];

   // Storage is not reset. Non-blocking write gives read-first behaviour
   // when a read and a write hit the same row on one edge.
   always_ff @(posedge clk) begin
      if (acc_valid) begin
         rd_q <= rd_word;
      end
      if (s_valid) begin
         mem[s_addr] <= wdata;
      end
   end

   always_comb begin
      wdata = '0;
      for (int i = 0; i < NB_LANE; i++) begin
         wdata[i*BUF_WIDTH +: BUF_WIDTH] = acc_lane(
            s_data[i*PE_OUT_WIDTH +: PE_OUT_WIDTH],
            fwd ? fwd_data[i*BUF_WIDTH +: BUF_WIDTH] : rd_q[i*BUF_WIDTH +: BUF_WIDTH],
            s_first);
      end
   end

   always_comb begin
      drain_row = '0;
      for (int i = 0; i < NB_LANE; i++) begin
         drain_row[i*BUF_WIDTH +: BUF_WIDTH] =
            drain_lane(rd_word[i*BUF_WIDTH +: BUF_WIDTH], drain_relu_en, drain_shift);
      end
   end

   // The read issued alongside a same-row write returns the stale row, so
   // the result being written is captured and used as the next operand.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_valid  <= 1'b0;
         s_first  <= 1'b0;
         s_addr   <= '0;
         s_data   <= '0;
         fwd      <= 1'b0;
         fwd_data <= '0;
      end else begin
         s_valid <= acc_valid;
         if (acc_valid) begin
            s_first <= acc_first;
            s_addr  <= acc_addr;
            s_data  <= acc_data;
         end
         fwd <= s_valid && acc_valid && (acc_addr == s_addr);
         if (s_valid) begin
            fwd_data <= wdata;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drain_valid <= 1'b0;
         drain_data  <= '0;
      end else begin
         drain_valid <= drain_acc;
         if (drain_acc) begin
            drain_data <= drain_row;
         end
      end
   end

endmodule

// File: tb/tb_acc_psum_buffer_bank.sv
module tb_acc_psum_buffer_bank;

   localparam int NB    = 8;
   localparam int PW    = 24;
   localparam int BW    = 16;
   localparam int DEPTH = 8192;
   localparam int AW    = 13;
   localparam int SW    = 4;

   logic              clk;
   logic              rst_n;
   logic              acc_valid;
   logic              acc_first;
   logic [AW-1:0]     acc_addr;
   logic [NB*PW-1:0]  acc_data;
   logic              drain_req;
   logic [AW-1:0]     drain_addr;
   logic              drain_relu_en;
   logic [SW-1:0]     drain_shift;
   logic              drain_ready;
   logic              drain_valid;
   logic [NB*BW-1:0]  drain_data;
   logic              busy;

   int                n_checks = 0;
   int                n_fail   = 0;
   int                n_dvalid = 0;
   logic [NB*BW-1:0]  sb [$];
   logic [NB*BW-1:0]  mon_exp;

   acc_psum_buffer_bank #(
      .NB_LANE(NB), .PE_OUT_WIDTH(PW), .BUF_WIDTH(BW),
      .BUF_DEPTH(DEPTH), .ADDR_WIDTH(AW), .SHIFT_WIDTH(SW)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .acc_valid(acc_valid), .acc_first(acc_first), .acc_addr(acc_addr), .acc_data(acc_data),
      .drain_req(drain_req), .drain_addr(drain_addr), .drain_relu_en(drain_relu_en),
      .drain_shift(drain_shift), .drain_ready(drain_ready), .drain_valid(drain_valid),
      .drain_data(drain_data), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [NB*PW-1:0] pe_lane(input int lane, input int val);
      logic [NB*PW-1:0] w;
      w = '0;
      w[lane*PW +: PW] = PW'(val);
      return w;
   endfunction

   function automatic logic [NB*BW-1:0] buf_lane(input int lane, input int val);
      logic [NB*BW-1:0] w;
      w = '0;
      w[lane*BW +: BW] = BW'(val);
      return w;
   endfunction

   // Scoreboard: each accepted drain pushes its expected row; every
   // drain_valid pops and compares.
   always @(negedge clk) begin
      if (rst_n && drain_valid) begin
         n_dvalid++;
         if (sb.size() == 0) begin
            check_eq("drain_unexpected", drain_valid, 0);
         end else begin
            mon_exp = sb.pop_front();
            check_eq("drain_data", drain_data, mon_exp);
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic acc_op(input int addr, input bit first, input logic [NB*PW-1:0] data);
      acc_valid = 1'b1;
      acc_first = first;
      acc_addr  = AW'(addr);
      acc_data  = data;
      @(posedge clk);
      #1;
      acc_valid = 1'b0;
      acc_first = 1'b0;
      acc_data  = '0;
   endtask

   task automatic drain(input int addr, input bit relu, input int sh, input logic [NB*BW-1:0] exp);
      int waited;
      waited        = 0;
      drain_req     = 1'b1;
      drain_addr    = AW'(addr);
      drain_relu_en = relu;
      drain_shift   = SW'(sh);
      @(negedge clk);
      while (!drain_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!drain_ready) begin
         check_eq("drain_timeout", drain_ready, 1);
         drain_req = 1'b0;
         @(posedge clk);
         #1;
         return;
      end
      sb.push_back(exp);
      @(posedge clk);
      #1;
      drain_req = 1'b0;
      @(negedge clk);
      check_eq("drain_valid_1cyc", drain_valid, 1);
      @(negedge clk);
      check_eq("drain_valid_drop", drain_valid, 0);
      check_eq("drain_hold", drain_data, exp);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int dv0;
      rst_n = 1'b0;
      acc_valid = 1'b0; acc_first = 1'b0; acc_addr = '0; acc_data = '0;
      drain_req = 1'b0; drain_addr = '0; drain_relu_en = 1'b0; drain_shift = '0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_drain_valid", drain_valid, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_drain_data", drain_data, 0);
      check_eq("rst_drain_ready", drain_ready, 1);
      rst_n = 1'b1;
      idle(1);

      // 1: first write then separated accumulate
      acc_op(5, 1, pe_lane(0, 100));
      check_eq("busy_stage_b", busy, 1);
      idle(3);
      acc_op(5, 0, pe_lane(0, 23));
      drain(5, 0, 0, buf_lane(0, 123));

      // 2: back-to-back accumulates to one row (forwarding)
      acc_op(7, 1, pe_lane(3, 10));
      acc_op(7, 0, pe_lane(3, 20));
      acc_op(7, 0, pe_lane(3, 30));
      drain(7, 0, 0, buf_lane(3, 60));

      // 3: saturation, including first-pass saturation on lanes 0 and 3
      acc_op(9, 1, pe_lane(1, 30000) | pe_lane(2, -30000) | pe_lane(0, 100000) | pe_lane(3, -100000));
      acc_op(9, 0, pe_lane(1, 5000) | pe_lane(2, -5000));
      drain(9, 0, 0, buf_lane(0, 32767) | buf_lane(1, 32767) | buf_lane(2, -32768) | buf_lane(3, -32768));
      drain(9, 0, 15, buf_lane(0, 1) | buf_lane(1, 1) | buf_lane(2, -1) | buf_lane(3, -1));

      // 4: drain transforms
      acc_op(11, 1, pe_lane(0, -50) | pe_lane(1, 10) | pe_lane(2, -10));
      idle(1);
      drain(11, 1, 2, buf_lane(1, 3));
      drain(11, 0, 2, buf_lane(0, -12) | buf_lane(1, 3) | buf_lane(2, -2));
      drain(11, 0, 0, buf_lane(0, -50) | buf_lane(1, 10) | buf_lane(2, -10));
      drain(11, 1, 0, buf_lane(1, 10));

      // 5: drain held while accumulates have priority
      dv0 = n_dvalid;
      drain_req = 1'b1; drain_addr = AW'(5); drain_relu_en = 1'b0; drain_shift = '0;
      for (int k = 0; k < 3; k++) begin
         acc_valid = 1'b1; acc_first = 1'b1; acc_addr = AW'(13 + k); acc_data = pe_lane(0, k);
         @(negedge clk);
         check_eq("ready_during_acc", drain_ready, 0);
         @(posedge clk);
         #1;
      end
      acc_valid = 1'b0; acc_first = 1'b0; acc_data = '0;
      @(negedge clk);
      check_eq("ready_while_busy", drain_ready, 0);
      check_eq("busy_tail", busy, 1);
      @(negedge clk);
      check_eq("ready_when_idle", drain_ready, 1);
      sb.push_back(buf_lane(0, 123));
      @(posedge clk);
      #1;
      drain_req = 1'b0;
      idle(4);
      check_eq("single_drain_valid", n_dvalid - dv0, 1);

      // 6: reset during stage B
      acc_valid = 1'b1; acc_first = 1'b1; acc_addr = AW'(5); acc_data = pe_lane(0, 999);
      @(posedge clk);
      #1;
      acc_valid = 1'b0; acc_first = 1'b0; acc_data = '0;
      check_eq("busy_before_rst", busy, 1);
      #1;
      rst_n = 1'b0;
      #1;
      check_eq("rst_mid_valid", drain_valid, 0);
      check_eq("rst_mid_busy", busy, 0);
      check_eq("rst_mid_data", drain_data, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      acc_op(5, 1, pe_lane(0, 7));
      drain(5, 0, 0, buf_lane(0, 7));

      idle(3);
      check_eq("sb_empty_end", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
